cpu_run_ctrl: RTL

CPU run controller between the PDU control bus and the CPU core. It turns the PDU run request, single-step pulse and breakpoint address into a per-cycle CPU clock enable. It halts the core before the breakpoint instruction executes and returns a one-cycle `cpu_stop` pulse to the PDU. It also supplies an enabled-cycle counter for the memory-map counter register.

---
 rtl/cpu_run_ctrl_pkg.sv | 20 ++
 rtl/cpu_run_ctrl_edge_rise.sv | 30 +++
 rtl/cpu_run_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run controller: state encodings,
// halt-cause codes and the breakpoint-disable value also used by the PDU.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } run_state_e;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_BP   = 2'b01;
    localparam logic [1:0] CAUSE_USER = 2'b10;
    localparam logic [1:0] CAUSE_STEP = 2'b11;

    // A breakpoint register holding this value means "no breakpoint".
    localparam logic [31:0] BP_DISABLE_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/cpu_run_ctrl_edge_rise.sv
// Registered rising-edge detector: rise is high in the cycle where sig_in
// is high and was low at the previous clock edge.
module cpu_run_ctrl_edge_rise (
    input  logic clk,
    input  logic rstn,
    input  logic sig_in,
    output logic rise
);

    logic sig_q;
    logic sig_d;

    // Next value of the delayed copy is simply the current input.
    always_comb begin
        sig_d = sig_in;
    end

    // Delayed copy of the input, cleared by reset so a level held high
    // across reset release counts as a fresh edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: converts PDU run/step/breakpoint controls into a
// per-cycle CPU clock enable, halts before a breakpoint instruction executes,
// reports the halt cause with a one-cycle cpu_stop pulse, and counts enabled
// cycles.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter logic [31:0] BP_DISABLE = BP_DISABLE_DEFAULT,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pdu_run,
    input  logic             pdu_step,
    input  logic [31:0]      pdu_breakpoint,
    input  logic [31:0]      current_pc,
    input  logic             cnt_clr,
    output logic             cpu_ce,
    output logic             cpu_stop,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] run_cycles
);

    run_state_e       state_q, state_d;
    logic             skip_q, skip_d;
    logic [1:0]       cause_q, cause_d;
    logic             stop_q, stop_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic run_rise;
    logic pc_match;
    logic bp_hit;
    logic ce;

    cpu_run_ctrl_edge_rise u_run_edge (
        .clk    (clk),
        .rstn   (rstn),
        .sig_in (pdu_run),
        .rise   (run_rise)
    );

    // Breakpoint compare and clock enable. The enable drops in the very cycle
    // the PC reaches the breakpoint, so that instruction never executes.
    // skip masks the compare once after resuming from that same PC.
    always_comb begin
        pc_match = (current_pc == pdu_breakpoint);
        bp_hit   = pc_match & (pdu_breakpoint != BP_DISABLE) & ~skip_q;
        ce       = ((state_q == ST_RUN) & pdu_run & ~bp_hit) | (state_q == ST_STEP);
    end

    // Next-state, skip, cause, stop-pulse and counter logic.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        skip_d  = skip_q;
        stop_d  = 1'b0;

        // Once the PC moves off the breakpoint, the resume mask is spent.
        if (skip_q && !pc_match) begin
            skip_d = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_HALT: begin
                // Run edge beats a coincident step; a held-high run does nothing.
                if (run_rise) begin
                    state_d = ST_RUN;
                    skip_d  = pc_match;
                end else if (pdu_step) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                // User stop outranks a breakpoint in the same cycle.
                if (!pdu_run) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_USER;
                    stop_d  = 1'b1;
                end else if (bp_hit) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_BP;
                    stop_d  = 1'b1;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
                cause_d = CAUSE_STEP;
                stop_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        halted_d = (state_d == ST_IDLE) || (state_d == ST_HALT);

        // Clear wins over a coincident increment; the add wraps naturally.
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (ce) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and registered outputs; reset forces IDLE, which also drops cpu_ce
    // immediately and suppresses any cpu_stop pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            skip_q   <= 1'b0;
            cause_q  <= CAUSE_NONE;
            stop_q   <= 1'b0;
            halted_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            skip_q   <= skip_d;
            cause_q  <= cause_d;
            stop_q   <= stop_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cpu_ce     = ce;
    assign cpu_stop   = stop_q;
    assign halted     = halted_q;
    assign halt_cause = cause_q;
    assign run_cycles = cnt_q;

endmodule
